// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end types: the fetch packet carried from fetch to decode
// and the canonical NOP encoding.
package riscv_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        pred_taken;
        logic [31:0] pred_pc;
    } fetch_pkt_t;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/fetch_decode_queue.sv
// In-order instruction queue between fetch and decode: circular buffer with
// valid/ready on the decode side, count-based back-pressure to fetch, and flush.
module fetch_decode_queue
    import riscv_pkg::*;
#(
    parameter int unsigned DEPTH     = 2,
    parameter logic [31:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     f_valid,
    input  logic [31:0]              f_pc,
    input  logic [31:0]              f_instr,
    input  logic                     f_pred_taken,
    input  logic [31:0]              f_pred_pc,
    output logic                     f_ready,
    input  logic                     flush,
    output logic                     d_valid,
    output logic [31:0]              d_pc,
    output logic [31:0]              d_instr,
    output logic                     d_pred_taken,
    output logic [31:0]              d_pred_pc,
    input  logic                     d_ready,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    fetch_pkt_t       mem [DEPTH];
    fetch_pkt_t       pkt_in;
    fetch_pkt_t       head;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push;
    logic             pop;

    // Ready looks only at the registered count, so a full queue never accepts
    // in the same cycle that decode drains it.
    assign f_ready = (count != CNT_W'(DEPTH));
    assign d_valid = (count != '0);
    assign push    = f_valid & f_ready & ~flush;
    assign pop     = d_valid & d_ready & ~flush;

    assign pkt_in.pc         = f_pc;
    assign pkt_in.instr      = f_instr;
    assign pkt_in.pred_taken = f_pred_taken;
    assign pkt_in.pred_pc    = f_pred_pc;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Entries are never cleared; stale data is hidden by d_valid masking below.
    always_ff @(posedge clk) begin
        if (push && !reset) begin
            mem[wr_ptr] <= pkt_in;
        end
    end

    assign head = mem[rd_ptr];

    always_comb begin
        d_pc         = '0;
        d_instr      = NOP_INSTR;
        d_pred_taken = 1'b0;
        d_pred_pc    = '0;
        if (d_valid) begin
            d_pc         = head.pc;
            d_instr      = head.instr;
            d_pred_taken = head.pred_taken;
            d_pred_pc    = head.pred_pc;
        end
    end

endmodule

// File: doc/fetch_decode_queue.md
Name: fetch_decode_queue

Overview:
- Parameterised instruction queue between the fetch stage and the decode stage.
- Captures each fetched packet (pc, instr, predicted-taken, predicted-pc) and presents packets in order to decode with a valid/ready handshake.
- Lets decode stall without losing in-flight fetches. Back-pressures fetch via f_ready (fetch holds its PC while f_ready=0).
- Empties completely on a redirect flush.

Parameters:
- DEPTH, 2: number of packet entries. Power of two, ≥2.
- NOP_INSTR, 32'h00000013: value driven on d_instr when the queue is empty (addi x0,x0,0).

Ports:
- clk, input, 1: clock.
- reset, input, 1: synchronous, active-high reset.
- f_valid, input, 1: fetch presents a packet this cycle.
- f_pc, input, 32: PC of the fetched instruction.
- f_instr, input, 32: fetched instruction word.
- f_pred_taken, input, 1: branch predictor chose predicted_pc for the next fetch.
- f_pred_pc, input, 32: predicted next PC accompanying this instruction.
- f_ready, output, 1: queue accepts a packet this cycle.
- flush, input, 1: redirect (mispredict/jump resolved in execute); discard all contents.
- d_valid, output, 1: head packet valid.
- d_pc, output, 32: head PC.
- d_instr, output, 32: head instruction.
- d_pred_taken, output, 1: head predicted-taken bit.
- d_pred_pc, output, 32: head predicted PC.
- d_ready, input, 1: decode consumes the head this cycle.
- count, output, $clog2(DEPTH)+1: current occupancy.

Behaviour:
- Storage: DEPTH-entry circular buffer, with wr_ptr and rd_ptr each $clog2(DEPTH) bits, plus a count register. Pointers wrap modulo DEPTH.
- Push condition: push = f_valid & f_ready & ~flush. The packet is written at wr_ptr and wr_ptr increments.
- Pop condition: pop = d_valid & d_ready & ~flush. rd_ptr increments.
- count update: count_next = count + push − pop. Simultaneous push and pop leaves count unchanged.
- f_ready = (count != DEPTH). It depends on registered count only, with no combinational path from d_ready. Consequently, when full, a same-cycle pop does not allow a push.
- d_valid = (count != 0).
- Head outputs: d_* come from the entry at rd_ptr. When empty, outputs are d_pc=0, d_instr=NOP_INSTR, d_pred_taken=0, d_pred_pc=0.
- Latency: a packet pushed in cycle N is visible on d_* in cycle N+1 at the earliest. There is no empty-queue bypass.
- Ordering: strict FIFO; packets are never reordered or duplicated.
- f_valid=1 while f_ready=0: the packet is not stored. Fetch is required to hold PC/instr until accepted.
- flush=1:
  - The next cycle has count=0, wr_ptr=0, rd_ptr=0, d_valid=0.
  - Flush dominates same-cycle push and pop; nothing is written and nothing is consumed.
  - f_ready stays driven from count, so it may be 1 during the flush cycle, but the flush-cycle packet is still dropped.
- reset=1 at a clock edge:
  - Same effect as flush: count=0, pointers=0, d_valid=0, f_ready=1 (DEPTH≠0), d_instr=NOP_INSTR, other d_* outputs = 0.
  - Reset mid-operation discards all entries.
  - Reset has priority over flush.
- Storage entries are not cleared on reset or flush. Only pointers and count are, and d_* are masked by d_valid.
- Wrap-around: after DEPTH pushes, wr_ptr returns to 0. Pointer equality is resolved by count (full vs empty).

Decomposition:
- riscv_pkg: typedef fetch_pkt_t as a packed struct {pc[31:0], instr[31:0], pred_taken, pred_pc[31:0]}, plus constant NOP_INSTR.
- Queue storage is declared as an array of fetch_pkt_t.
- Single module; no sub-module warranted.
- Fetch connects f_ready to its PC hold enable. Decode connects its stall to d_ready.

Test Plan:
- Reset: assert reset 2 cycles → d_valid=0, count=0, f_ready=1, d_instr=32'h00000013, d_pc=0.
- Fill/drain, DEPTH=2, d_ready=0: push pc 0x0 and 0x4 → count=2, f_ready=0. A third packet (pc 0x8) is held by fetch. Raise d_ready → d_pc 0x0 then 0x4 on consecutive cycles, then 0x8 is accepted.
- Streaming, f_valid=d_ready=1, pcs 0x0, 0x4, 0x8, …: after 1-cycle fill, one packet pops per cycle, count stays 1, d_pc sequence matches input. Pointers wrap past DEPTH with no gap.
- Flush with count=2 and simultaneous push of pc 0x100 → next cycle count=0, d_valid=0. pc 0x100 is never seen. The next push after the flush (pc 0x200, f_pred_taken=1, f_pred_pc 0x300) appears one cycle later with d_pred_taken=1, d_pred_pc=0x300.
- Full with simultaneous pop: count=2, d_ready=1, f_valid=1 → pop occurs, no push, count=1. The packet is accepted the following cycle.
- Reset mid-stream with count=1 and f_valid=1 → next cycle count=0, d_valid=0, packet discarded.
